// File: rtl/gio_input_ctrl.sv
// General-purpose input controller: per-pin synchroniser, debouncer, edge-event
// latch with W1C clear, interrupt mask and a 4-entry 16-bit register window.
module gio_input_ctrl #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int EDGE_MODE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] GIO_pins,
    input  logic             rd_en,
    input  logic             wr_en,
    input  logic [1:0]       addr,
    input  logic [15:0]      wr_data,
    output logic [15:0]      rd_data,
    output logic             irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_STATE = 2'd0;
    localparam logic [1:0] ADDR_EVENT = 2'd1;
    localparam logic [1:0] ADDR_MASK  = 2'd2;
    localparam logic [1:0] ADDR_RAW   = 2'd3;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0][CW-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]                  stable_q, stable_d;
    logic [WIDTH-1:0]                  event_q, event_d;
    logic [WIDTH-1:0]                  mask_q, mask_d;
    logic [WIDTH-1:0]                  raw;
    logic [WIDTH-1:0]                  set_ev;
    logic [WIDTH-1:0]                  clr_ev;
    logic [15:0]                       rd_data_q, rd_data_d;
    logic                              irq_q, irq_d;

    assign raw = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d[0] = GIO_pins;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    // A pin's stable level only moves after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        set_ev   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (raw[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = raw[i];
                cnt_d[i]    = '0;
                if (EDGE_MODE == 0) begin
                    set_ev[i] = raw[i];
                end else if (EDGE_MODE == 1) begin
                    set_ev[i] = ~raw[i];
                end else begin
                    set_ev[i] = 1'b1;
                end
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Register strobes: rd_en/wr_en are single-cycle requests accepted on every
    // rising edge they are high (no ready); read data lands one edge later and a
    // same-cycle read returns the value from before the write.
    always_comb begin
        clr_ev = '0;
        mask_d = mask_q;
        if (wr_en && addr == ADDR_EVENT) begin
            clr_ev = wr_data[WIDTH-1:0];
        end
        if (wr_en && addr == ADDR_MASK) begin
            mask_d = wr_data[WIDTH-1:0];
        end
        event_d = (event_q & ~clr_ev) | set_ev;
        irq_d   = |(event_q & mask_q);
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            case (addr)
                ADDR_STATE: rd_data_d = 16'(stable_q);
                ADDR_EVENT: rd_data_d = 16'(event_q);
                ADDR_MASK:  rd_data_d = 16'(mask_q);
                ADDR_RAW:   rd_data_d = 16'(raw);
                default:    rd_data_d = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            stable_q  <= '0;
            event_q   <= '0;
            mask_q    <= '0;
            rd_data_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            event_q   <= event_d;
            mask_q    <= mask_d;
            rd_data_q <= rd_data_d;
            irq_q     <= irq_d;
        end
    end

    assign rd_data = rd_data_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_gio_input_ctrl.sv
// Directed bench for gio_input_ctrl: three instances share stimulus and differ
// only in EDGE_MODE (0 rising, 1 falling, 2 both).
module tb_gio_input_ctrl;

    localparam logic [1:0] A_STATE = 2'd0;
    localparam logic [1:0] A_EVENT = 2'd1;
    localparam logic [1:0] A_MASK  = 2'd2;
    localparam logic [1:0] A_RAW   = 2'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  pins;
    logic        rd_en;
    logic        wr_en;
    logic [1:0]  addr;
    logic [15:0] wr_data;
    logic [15:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    gio_input_ctrl #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .GIO_pins(pins), .rd_en(rd_en), .wr_en(wr_en),
        .addr(addr), .wr_data(wr_data), .rd_data(rd0), .irq(irq0)
    );
    gio_input_ctrl #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(1)) dut1 (
        .clk(clk), .reset(reset), .GIO_pins(pins), .rd_en(rd_en), .wr_en(wr_en),
        .addr(addr), .wr_data(wr_data), .rd_data(rd1), .irq(irq1)
    );
    gio_input_ctrl #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2)) dut2 (
        .clk(clk), .reset(reset), .GIO_pins(pins), .rd_en(rd_en), .wr_en(wr_en),
        .addr(addr), .wr_data(wr_data), .rd_data(rd2), .irq(irq2)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic bus(input logic r, input logic w, input logic [1:0] a, input logic [15:0] d);
        rd_en   = r;
        wr_en   = w;
        addr    = a;
        wr_data = d;
        tick();
        rd_en   = 1'b0;
        wr_en   = 1'b0;
    endtask

    // Holds a read of one address every cycle and checks rd0 against exp_q;
    // optionally changes the pins right after sample number chg_at.
    task automatic stream(input string tag, input logic [1:0] a, input int chg_at,
                          input logic [7:0] chg_val);
        int n;
        n     = 0;
        rd_en = 1'b1;
        addr  = a;
        while (exp_q.size() > 0) begin
            tick();
            n++;
            check(tag, rd0, exp_q.pop_front());
            if (n == chg_at) pins = chg_val;
        end
        rd_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset   = 1'b1;
        pins    = 8'hBF;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        addr    = 2'd0;
        wr_data = 16'h0000;

        // Reset values and first qualification after release
        tick();
        tick();
        check("rst_rd_data", rd0, 16'h0000);
        check("rst_irq", {15'd0, irq0}, 16'h0000);
        reset = 1'b0;
        bus(1'b1, 1'b0, A_STATE, 16'h0);
        check("rst_state", rd0, 16'h0000);
        bus(1'b1, 1'b0, A_EVENT, 16'h0);
        check("rst_event", rd0, 16'h0000);
        bus(1'b1, 1'b0, A_MASK, 16'h0);
        check("rst_mask", rd0, 16'h0000);
        idle(2);
        bus(1'b1, 1'b0, A_STATE, 16'h0);
        check("state_before_qual", rd0, 16'h0000);
        bus(1'b1, 1'b0, A_STATE, 16'h0);
        check("state_after_qual", rd0, 16'h00BF);
        bus(1'b1, 1'b0, A_EVENT, 16'h0);
        check("event_after_qual", rd0, 16'h00BF);
        tick();
        check("rd_data_hold", rd0, 16'h00BF);
        bus(1'b1, 1'b0, A_RAW, 16'h0);
        check("raw_bf", rd0, 16'h00BF);
        check("irq_unmasked_off", {15'd0, irq0}, 16'h0000);

        pins = 8'h00;
        idle(8);
        bus(1'b0, 1'b1, A_EVENT, 16'hFFFF);

        // Glitch rejection: 3-cycle pulse on pin 0 seen on RAW but not STATE
        pins = 8'h01;
        exp_q = '{16'h0000, 16'h0000, 16'h0001, 16'h0001, 16'h0001, 16'h0000};
        stream("raw_pulse", A_RAW, 3, 8'h00);
        bus(1'b1, 1'b0, A_STATE, 16'h0);
        check("glitch_state", rd0, 16'h0000);
        bus(1'b1, 1'b0, A_EVENT, 16'h0);
        check("glitch_event", rd0, 16'h0000);

        // 4-cycle pulse qualifies at edge k+5, visible on rd_data one edge later
        pins = 8'h01;
        exp_q = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001};
        stream("qual_state", A_STATE, -1, 8'h00);
        bus(1'b1, 1'b0, A_EVENT, 16'h0);
        check("qual_event", rd0, 16'h0001);

        // Mask and interrupt
        check("irq_masked", {15'd0, irq0}, 16'h0000);
        bus(1'b0, 1'b1, A_MASK, 16'h0001);
        check("irq_mask_edge", {15'd0, irq0}, 16'h0000);
        tick();
        check("irq_set", {15'd0, irq0}, 16'h0001);
        bus(1'b0, 1'b1, A_EVENT, 16'h0001);
        check("irq_clr_edge", {15'd0, irq0}, 16'h0001);
        bus(1'b1, 1'b0, A_EVENT, 16'h0);
        check("event_w1c", rd0, 16'h0000);
        check("irq_cleared", {15'd0, irq0}, 16'h0000);

        // Read/write collision, unused upper bits, read-only addresses
        bus(1'b1, 1'b1, A_MASK, 16'hFFFF);
        check("rdwr_prewrite", rd0, 16'h0001);
        bus(1'b1, 1'b0, A_MASK, 16'h0);
        check("mask_upper_zero", rd0, 16'h00FF);
        bus(1'b0, 1'b1, A_STATE, 16'hFFFF);
        bus(1'b1, 1'b0, A_STATE, 16'h0);
        check("state_ro", rd0, 16'h0001);
        bus(1'b0, 1'b1, A_RAW, 16'hFFFF);
        bus(1'b1, 1'b0, A_RAW, 16'h0);
        check("raw_ro", rd0, 16'h0001);
        bus(1'b0, 1'b1, A_MASK, 16'h0001);

        // Set/clear collision on pin 3: W1C lands on the qualifying edge
        pins = 8'h09;
        idle(5);
        bus(1'b0, 1'b1, A_EVENT, 16'h0008);
        bus(1'b1, 1'b0, A_EVENT, 16'h0);
        check("set_wins", rd0, 16'h0008);
        bus(1'b0, 1'b1, A_EVENT, 16'h0008);
        bus(1'b1, 1'b0, A_EVENT, 16'h0);
        check("w1c_after", rd0, 16'h0000);

        // Edge modes on pin 7
        bus(1'b0, 1'b1, A_EVENT, 16'hFFFF);
        pins = 8'h89;
        idle(8);
        bus(1'b1, 1'b0, A_EVENT, 16'h0);
        check("rise_mode0", rd0, 16'h0080);
        check("rise_mode1", rd1, 16'h0000);
        check("rise_mode2", rd2, 16'h0080);
        bus(1'b0, 1'b1, A_EVENT, 16'hFFFF);
        pins = 8'h09;
        idle(8);
        bus(1'b1, 1'b0, A_EVENT, 16'h0);
        check("fall_mode0", rd0, 16'h0000);
        check("fall_mode1", rd1, 16'h0080);
        check("fall_mode2", rd2, 16'h0080);

        // Reset while pin 2 sits at cnt=2
        pins = 8'h0D;
        idle(4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_rd_data", rd0, 16'h0000);
        check("midrst_irq", {15'd0, irq0}, 16'h0000);
        exp_q = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h000D};
        stream("midrst_state", A_STATE, -1, 8'h00);
        bus(1'b1, 1'b0, A_MASK, 16'h0);
        check("midrst_mask", rd0, 16'h0000);
        bus(1'b1, 1'b0, A_EVENT, 16'h0);
        check("midrst_event", rd0, 16'h000D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
